// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sort_fsm block.
//   state_e     : controller states (LOAD, SORT, DRAIN)
//   PHASE_EVEN  : parity of a phase that compares pairs (0,1),(2,3),...
//   PHASE_ODD   : parity of a phase that compares pairs (1,2),(3,4),...
// ---------------------------------------------------------------------------
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic PHASE_EVEN = 1'b0;
    localparam logic PHASE_ODD  = 1'b1;

endpackage

// File: rtl/sort_fsm_if.sv
// ---------------------------------------------------------------------------
// sort_fsm_if
// Handshake and data bundle between a producer/consumer and sort_fsm.
//   in_data/in_valid/in_ready      : load side (valid/ready)
//   descend                        : requested sort order for the next frame
//   out_data/out_valid/out_ready   : drain side (valid/ready)
//   out_last                       : final word of a frame
//   busy                           : block is sorting
// Modports: slave = the sorter, master = the environment driving it.
// ---------------------------------------------------------------------------
interface sort_fsm_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             descend;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    modport slave (
        input  in_data, in_valid, descend, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );

    modport master (
        output in_data, in_valid, descend, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/sort_fsm_cmp_swap.sv
// ---------------------------------------------------------------------------
// cmp_swap
// One compare-and-conditional-swap element of the sorting network.
//   a_i, b_i   : words at the lower and upper index of the pair
//   descend_i  : 0 keeps the smaller word low, 1 keeps the larger word low
//   lo_o, hi_o : words written back to the lower and upper index
// Equal words never swap. Comparison is unsigned unless the macro
// SORT_FSM_SIGNED_EN is defined, in which case it is two's-complement.
// ---------------------------------------------------------------------------
module cmp_swap #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             descend_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    logic aGtB;
    logic aLtB;
    logic swap;

    // Magnitude relation between the two words in the configured number format.
`ifdef SORT_FSM_SIGNED_EN
    assign aGtB = $signed(a_i) > $signed(b_i);
    assign aLtB = $signed(a_i) < $signed(b_i);
`else
    assign aGtB = a_i > b_i;
    assign aLtB = a_i < b_i;
`endif

    // A pair is out of order when the low slot holds the word that belongs high.
    assign swap = descend_i ? aLtB : aGtB;

    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort_fsm.sv
// ---------------------------------------------------------------------------
// sort_fsm
// Frame sorter: loads DEPTH words, sorts them in place with DEPTH phases of
// odd-even transposition (one phase per clock), then drains them in order.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : sort_fsm_if.slave (load handshake, descend, drain handshake,
//              out_last, busy)
// Parameters: WIDTH data bits (>=2), DEPTH words per frame (even, >=2).
// Optional build macro SORT_FSM_SIGNED_EN selects signed comparison inside
// cmp_swap; by default words compare as unsigned.
// ---------------------------------------------------------------------------
module sort_fsm
    import sort_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    sort_fsm_if.slave   bus
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    phase_q, phase_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] frameBuf_q [DEPTH];
    logic [WIDTH-1:0] evenNet    [DEPTH];
    logic [WIDTH-1:0] oddNet     [DEPTH];
    logic [WIDTH-1:0] sortNet    [DEPTH];

    logic             loadWr;
    logic             sortWr;

    // Even-phase network: every word belongs to exactly one pair.
    for (genvar k = 0; k < DEPTH / 2; k++) begin : g_even
        cmp_swap #(.WIDTH(WIDTH)) u_cmp (
            .a_i       (frameBuf_q[2*k]),
            .b_i       (frameBuf_q[2*k+1]),
            .descend_i (mode_q),
            .lo_o      (evenNet[2*k]),
            .hi_o      (evenNet[2*k+1])
        );
    end

    // Odd-phase network: the first and last words sit out and pass through.
    for (genvar k = 0; k < DEPTH / 2 - 1; k++) begin : g_odd
        cmp_swap #(.WIDTH(WIDTH)) u_cmp (
            .a_i       (frameBuf_q[2*k+1]),
            .b_i       (frameBuf_q[2*k+2]),
            .descend_i (mode_q),
            .lo_o      (oddNet[2*k+1]),
            .hi_o      (oddNet[2*k+2])
        );
    end
    assign oddNet[0]       = frameBuf_q[0];
    assign oddNet[DEPTH-1] = frameBuf_q[DEPTH-1];

    // Pick the network result matching the parity of the current phase.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sortNet[i] = (phase_q[0] == PHASE_ODD) ? oddNet[i] : evenNet[i];
        end
    end

    // Next-state logic. cnt indexes the buffer while loading and draining;
    // phase counts sort passes. The order request is captured only on the
    // edge that accepts the final word so later changes cannot disturb a frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        loadWr  = 1'b0;
        sortWr  = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    loadWr = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = SORT;
                        cnt_d   = '0;
                        phase_d = '0;
                        mode_d  = bus.descend;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SORT: begin
                sortWr = 1'b1;
                if (phase_q == LAST) begin
                    state_d = DRAIN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    // Control registers; reset returns to an empty LOAD state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            phase_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
        end
    end

    // Word storage is deliberately not reset; a reset simply abandons the frame.
    always_ff @(posedge clk) begin
        if (loadWr) begin
            frameBuf_q[cnt_q] <= bus.in_data;
        end else if (sortWr) begin
            for (int i = 0; i < DEPTH; i++) begin
                frameBuf_q[i] <= sortNet[i];
            end
        end
    end

    // Outputs decode straight from registers so reset takes effect at once.
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.busy      = (state_q == SORT);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_last  = (state_q == DRAIN) && (cnt_q == LAST);
    assign bus.out_data  = frameBuf_q[cnt_q];

endmodule

// File: tb/tb_sort_fsm.sv
// ---------------------------------------------------------------------------
// tb_sort_fsm
// Directed self-checking bench for sort_fsm with WIDTH=16, DEPTH=8.
// ---------------------------------------------------------------------------
module tb_sort_fsm;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sort_fsm_if #(.WIDTH(WIDTH)) bus ();

    sort_fsm #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [WIDTH-1:0] frameIn  [DEPTH];
    logic [WIDTH-1:0] frameExp [DEPTH];

    // Offer the words of frameIn back to back; in_ready must be high for each.
    task automatic loadFrame(input string tag, input logic desc);
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_data  = frameIn[i];
            bus.in_valid = 1'b1;
            bus.descend  = desc;
            testsRun++;
            if (bus.in_ready !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL %s load_ready[%0d]: got %b want 1", tag, i, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Walk through the sort phases; out_valid must rise exactly DEPTH edges
    // after the final load edge. Optionally wiggle descend meanwhile.
    task automatic waitSort(input string tag, input bit toggleDesc);
        logic expValid;
        for (int i = 1; i <= DEPTH; i++) begin
            if (toggleDesc) bus.descend = ~bus.descend;
            @(posedge clk);
            #1;
            expValid = (i == DEPTH);
            testsRun++;
            if (bus.out_valid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL %s latency_valid[%0d]: got %b want %b", tag, i, bus.out_valid, expValid);
            end
            testsRun++;
            if (bus.busy !== ~expValid) begin
                testsFailed++;
                $display("[TB] FAIL %s busy[%0d]: got %b want %b", tag, i, bus.busy, ~expValid);
            end
            testsRun++;
            if (bus.in_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s sort_in_ready[%0d]: got %b want 0", tag, i, bus.in_ready);
            end
        end
    endtask

    // Collect the frame against frameExp, checking order, out_last and that a
    // stalled word holds until taken. Bounded so a dead DUT cannot hang us.
    task automatic drainFrame(input string tag, input bit randomReady);
        int               idx = 0;
        int               cycles = 0;
        bit               prevStalled = 0;
        logic [WIDTH-1:0] prevData = '0;
        logic             prevLast = 1'b0;
        logic             rdy;
        logic             expLast;
        while (idx < DEPTH && cycles < 200) begin
            testsRun++;
            if (bus.out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL %s drain_valid[%0d]: got %b want 1", tag, idx, bus.out_valid);
            end
            if (prevStalled) begin
                testsRun++;
                if (bus.out_data !== prevData || bus.out_last !== prevLast) begin
                    testsFailed++;
                    $display("[TB] FAIL %s hold[%0d]: got %h/%b want %h/%b", tag, idx,
                             bus.out_data, bus.out_last, prevData, prevLast);
                end
            end
            rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            if (rdy) begin
                expLast = (idx == DEPTH - 1);
                testsRun++;
                if (bus.out_data !== frameExp[idx]) begin
                    testsFailed++;
                    $display("[TB] FAIL %s data[%0d]: got %h want %h", tag, idx, bus.out_data, frameExp[idx]);
                end
                testsRun++;
                if (bus.out_last !== expLast) begin
                    testsFailed++;
                    $display("[TB] FAIL %s last[%0d]: got %b want %b", tag, idx, bus.out_last, expLast);
                end
                idx++;
                prevStalled = 0;
            end else begin
                prevStalled = 1;
                prevData    = bus.out_data;
                prevLast    = bus.out_last;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.out_ready = 1'b0;
        testsRun++;
        if (idx != DEPTH) begin
            testsFailed++;
            $display("[TB] FAIL %s drain_timeout: got %0d words want %0d", tag, idx, DEPTH);
        end
        testsRun++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s back_to_load: got in_ready=%b out_valid=%b want 1/0", tag,
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.descend   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        testsRun++;
        if (bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        testsRun++;
        if (bus.out_last !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_last: got %b want 0", bus.out_last);
        end
        testsRun++;
        if (bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
        end
        #10;
        rst = 1'b0;
    endtask

    task automatic test_ascend();
        frameIn  = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd5};
        frameExp = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        loadFrame("ascend", 1'b0);
        waitSort("ascend", 1'b0);
        drainFrame("ascend", 1'b0);
    endtask

    task automatic test_descend();
        frameIn  = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd5};
        frameExp = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd3, 16'd2, 16'd1};
        loadFrame("descend", 1'b1);
        waitSort("descend", 1'b1);
        bus.descend = 1'b0;
        drainFrame("descend", 1'b0);
    endtask

    task automatic test_backpressure();
        frameIn  = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0005, 16'h0005, 16'h0000, 16'hFFFF};
        frameExp = '{16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0005, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        loadFrame("backpressure", 1'b0);
        waitSort("backpressure", 1'b0);
        drainFrame("backpressure", 1'b1);
    endtask

    task automatic test_reset_mid_sort();
        frameIn = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd5};
        loadFrame("rst_sort", 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        testsRun++;
        if (bus.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_sort_busy_before: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        testsRun++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_sort_immediate: got valid=%b ready=%b busy=%b want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        #1;
        rst = 1'b0;
        frameIn  = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        frameExp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        loadFrame("rst_next", 1'b0);
        waitSort("rst_next", 1'b0);
        drainFrame("rst_next", 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        frameIn = '{16'd4, 16'd2, 16'd3, 16'd1, 16'd8, 16'd6, 16'd7, 16'd5};
        loadFrame("rst_drain", 1'b0);
        waitSort("rst_drain", 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        testsRun++;
        if (bus.out_last !== 1'b1 || bus.out_data !== 16'd8) begin
            testsFailed++;
            $display("[TB] FAIL rst_drain_last_word: got %h/%b want 0008/1", bus.out_data, bus.out_last);
        end
        rst = 1'b1;
        #1;
        testsRun++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_drain_immediate: got valid=%b last=%b ready=%b want 0/0/1",
                     bus.out_valid, bus.out_last, bus.in_ready);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_signed();
        frameIn = '{16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0002, 16'h0003, 16'h0004};
`ifdef SORT_FSM_SIGNED_EN
        frameExp = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h7FFF};
`else
        frameExp = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h7FFF, 16'h8000, 16'hFFFF};
`endif
        loadFrame("signed", 1'b0);
        waitSort("signed", 1'b0);
        drainFrame("signed", 1'b0);
    endtask

    initial begin
        test_reset();
        test_ascend();
        test_descend();
        test_backpressure();
        test_reset_mid_sort();
        test_reset_mid_drain();
        test_signed();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sort_fsm.md
SORT_FSM -- requirements
Module: sort_fsm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the data word width in bits (>=2).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving words per sort frame (even, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_data, input, WIDTH, the word to load.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-008 The block SHALL have port descend, input, 1, selecting sort order (0 ascending, 1 descending).
REQ-009 The block SHALL have port out_data, output, WIDTH, the sorted word.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_data.
REQ-012 The block SHALL have port out_last, output, 1, marking the final word of a frame.
REQ-013 The block SHALL have port busy, output, 1, high in SORT state.

Function
REQ-014 The FSM SHALL have three states, LOAD, SORT and DRAIN, in a DEPTH-entry WIDTH-bit register buffer.
REQ-015 In LOAD, in_ready SHALL be 1, and each in_valid&&in_ready edge writes buf[cnt] and increments cnt.
REQ-016 On the edge accepting word DEPTH-1, the FSM SHALL enter SORT, clear cnt and latch descend into the mode register.
REQ-017 In SORT, each cycle SHALL perform one odd-even transposition phase: even phases compare pairs (0,1),(2,3)...; odd phases compare pairs (1,2),(3,4)....
REQ-018 Each compared pair SHALL swap when it is out of order for the latched mode; equal values never swap.
REQ-019 After exactly DEPTH phases the FSM SHALL enter DRAIN, so out_valid rises DEPTH cycles after the final load edge.
REQ-020 In DRAIN, out_data SHALL be buf[cnt], out_valid 1, and cnt increments on each out_valid&&out_ready edge.
REQ-021 out_last SHALL be 1 when out_valid and cnt==DEPTH-1; the accepting edge returns the FSM to LOAD with cnt=0.
REQ-022 With out_ready low, out_data, out_valid and out_last SHALL hold stable.
REQ-023 in_ready SHALL be 0 in SORT and DRAIN; in_valid is ignored there.
REQ-024 A descend change after the latch SHALL NOT affect the current frame.
REQ-025 Comparison SHALL be unsigned over the full WIDTH unless REQ-029 applies.

Reset
REQ-026 Asserting rst SHALL immediately force state LOAD, cnt 0, mode 0, out_valid 0, out_last 0, busy 0 and in_ready 1.
REQ-027 Buffer contents SHALL NOT be reset; reset during SORT or DRAIN discards the frame.
REQ-028 The first edge after rst deasserts SHALL be able to accept a word.

Configuration
REQ-029 With macro SORT_FSM_SIGNED_EN defined, comparisons SHALL be two's-complement signed; without it they are unsigned.

Structure
REQ-030 A shared package sort_pkg SHALL hold the state enum (LOAD, SORT, DRAIN) and the phase-parity constants.
REQ-031 A sub-module cmp_swap SHALL implement one compare-and-conditional-swap on two WIDTH-bit words with a descend input.

Verification (WIDTH=16, DEPTH=8)
REQ-032 Load 7,3,9,1,8,2,6,5 with descend=0 and out_ready=1 -> out 1,2,3,5,6,7,8,9; out_last only on 9; out_valid 8 cycles after the last load.
REQ-033 Load the same frame with descend=1, toggling descend after the load -> out 9,8,7,6,5,3,2,1.
REQ-034 Load 0xFFFF,0,0xFFFF,0,5,5,0,0xFFFF ascending with out_ready random 50% -> 0,0,0,5,5,0xFFFF,0xFFFF,0xFFFF; no loss or duplication; data held while stalled.
REQ-035 Assert rst in SORT phase 3 -> out_valid 0 and in_ready 1 at once; the next frame 8..1 sorts to 1..8 unaffected.
REQ-036 With SORT_FSM_SIGNED_EN, load 0x8000,1,0x7FFF,0xFFFF,0,2,3,4 ascending -> 0x8000,0xFFFF,0,1,2,3,4,0x7FFF; without it 0xFFFF is last.
